fpm_pipelined: RTL and testbench

//  Parametrised, pipelined IEEE-754-style floating-point multiplier with valid/ready handshake.

---
 rtl/fpm_pipelined.sv | 176 +++++++++++++++++
 tb/tb_fpm_pipelined.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpm_pipelined.sv
// fpm_pipelined: three-stage floating-point multiplier with a valid/ready
// handshake on both sides and a user tag carried alongside each operation.
//
//   S1  unpack, sign XOR, biased exponent sum, special-value classification
//   S2  (M+1)x(M+1) significand multiply
//   S3  normalise, round (truncate or RNE), overflow/underflow, pack
//
// Ports
//   clock, reset                 single clock, synchronous active-high reset
//   valid_in / ready_in          operand handshake (ready_in is combinational)
//   a_in, b_in, tag_in           operands {sign, exp, frac} and tag
//   valid_out / ready_out        result handshake
//   fpm_out, tag_out             product and its tag
//   overflow_out, underflow_out  result saturated to infinity / flushed to zero
module fpm_pipelined #(
    parameter int EXP_WIDTH      = 8,
    parameter int MANTISSA_WIDTH = 23,
    parameter int ROUND_MODE     = 1,
    parameter int TAG_WIDTH      = 4
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                valid_in,
    output logic                                ready_in,
    input  logic [EXP_WIDTH+MANTISSA_WIDTH:0]   a_in,
    input  logic [EXP_WIDTH+MANTISSA_WIDTH:0]   b_in,
    input  logic [TAG_WIDTH-1:0]                tag_in,
    output logic                                valid_out,
    input  logic                                ready_out,
    output logic [EXP_WIDTH+MANTISSA_WIDTH:0]   fpm_out,
    output logic [TAG_WIDTH-1:0]                tag_out,
    output logic                                overflow_out,
    output logic                                underflow_out
);

    localparam int E  = EXP_WIDTH;
    localparam int M  = MANTISSA_WIDTH;
    localparam int W  = E + M + 1;
    localparam int PW = 2 * M + 2;
    localparam int EW = E + 2;

    localparam logic [EW-1:0] BIAS     = EW'((1 << (E - 1)) - 1);
    localparam logic [EW-1:0] EXP_MAX  = EW'((1 << E) - 1);
    localparam logic [E-1:0]  EXP_ONES = '1;
    localparam logic [M-1:0]  NAN_FRAC = {1'b1, {(M - 1){1'b0}}};

    typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF, SP_ZERO} special_t;

    logic advance;
    assign advance  = ready_out | ~valid_out;
    assign ready_in = advance;

    // ---------------- S1: unpack and classify ----------------
    logic         sa, sb;
    logic [E-1:0] ea, eb;
    logic [M-1:0] fa, fb;
    logic         a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    special_t     spec_d;

    assign {sa, ea, fa} = a_in;
    assign {sb, eb, fb} = b_in;

    always_comb begin
        a_nan  = (ea == EXP_ONES) && (fa != '0);
        b_nan  = (eb == EXP_ONES) && (fb != '0);
        a_inf  = (ea == EXP_ONES) && (fa == '0);
        b_inf  = (eb == EXP_ONES) && (fb == '0);
        // Exponent zero covers subnormals too: they are flushed on input.
        a_zero = (ea == '0);
        b_zero = (eb == '0);
        spec_d = SP_NONE;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
            spec_d = SP_NAN;
        else if (a_inf || b_inf)
            spec_d = SP_INF;
        else if (a_zero || b_zero)
            spec_d = SP_ZERO;
    end

    logic          s1_v, s1_sign;
    logic [EW-1:0] s1_exp;
    logic [M:0]    s1_ma, s1_mb;
    special_t      s1_spec;
    logic [TAG_WIDTH-1:0] s1_tag;

    // ---------------- S2: significand multiply ----------------
    logic          s2_v, s2_sign;
    logic [EW-1:0] s2_exp;
    logic [PW-1:0] s2_prod;
    special_t      s2_spec;
    logic [TAG_WIDTH-1:0] s2_tag;

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
        end else if (advance) begin
            s1_v    <= valid_in;
            s1_sign <= sa ^ sb;
            s1_exp  <= {2'b00, ea} + {2'b00, eb} - BIAS;
            s1_ma   <= {1'b1, fa};
            s1_mb   <= {1'b1, fb};
            s1_spec <= spec_d;
            s1_tag  <= tag_in;

            s2_v    <= s1_v;
            s2_sign <= s1_sign;
            s2_exp  <= s1_exp;
            s2_prod <= PW'(s1_ma) * PW'(s1_mb);
            s2_spec <= s1_spec;
            s2_tag  <= s1_tag;
        end
    end

    // ---------------- S3: normalise, round, pack ----------------
    logic [EW-1:0] e_norm, e_fin;
    logic [M-1:0]  frac_t;
    logic [M:0]    frac_r;
    logic          guard, sticky, round_up;
    logic          ovf_d, unf_d;
    logic [W-1:0]  fpm_d;

    always_comb begin
        if (s2_prod[PW-1]) begin
            frac_t = s2_prod[PW-2:M+1];
            guard  = s2_prod[M];
            sticky = |s2_prod[M-1:0];
            e_norm = s2_exp + EW'(1);
        end else begin
            frac_t = s2_prod[PW-3:M];
            guard  = s2_prod[M-1];
            sticky = |s2_prod[M-2:0];
            e_norm = s2_exp;
        end
        round_up = (ROUND_MODE == 1) && guard && (sticky || frac_t[0]);
        // A rounding carry leaves the fraction field all-zero, so only the
        // exponent needs bumping; range checks run on the final exponent.
        frac_r = {1'b0, frac_t} + (M + 1)'(round_up);
        e_fin  = e_norm + EW'(frac_r[M]);

        ovf_d = 1'b0;
        unf_d = 1'b0;
        fpm_d = {s2_sign, e_fin[E-1:0], frac_r[M-1:0]};
        case (s2_spec)
            SP_NAN:  fpm_d = {1'b0, EXP_ONES, NAN_FRAC};
            SP_INF:  fpm_d = {s2_sign, EXP_ONES, {M{1'b0}}};
            SP_ZERO: fpm_d = {s2_sign, {(W - 1){1'b0}}};
            default: begin
                if ($signed(e_fin) >= $signed(EXP_MAX)) begin
                    fpm_d = {s2_sign, EXP_ONES, {M{1'b0}}};
                    ovf_d = 1'b1;
                end else if ($signed(e_fin) <= 0) begin
                    fpm_d = {s2_sign, {(W - 1){1'b0}}};
                    unf_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_out     <= 1'b0;
            fpm_out       <= '0;
            tag_out       <= '0;
            overflow_out  <= 1'b0;
            underflow_out <= 1'b0;
        end else if (advance) begin
            valid_out     <= s2_v;
            fpm_out       <= fpm_d;
            tag_out       <= s2_tag;
            overflow_out  <= ovf_d & s2_v;
            underflow_out <= unf_d & s2_v;
        end
    end

endmodule

// File: tb/tb_fpm_pipelined.sv
// Scoreboard bench for fpm_pipelined (single precision). Two instances share
// all inputs: one rounds to nearest-even, one truncates.
module tb_fpm_pipelined;

    logic        clock = 1'b0;
    logic        reset;
    logic        valid_in;
    logic        ready_in, ready_in_t;
    logic [31:0] a_in, b_in;
    logic [3:0]  tag_in;
    logic        valid_out, valid_out_t;
    logic        ready_out;
    logic [31:0] fpm_out, fpm_out_t;
    logic [3:0]  tag_out, tag_out_t;
    logic        overflow_out, overflow_out_t;
    logic        underflow_out, underflow_out_t;

    always #5 clock = ~clock;

    fpm_pipelined #(.EXP_WIDTH(8), .MANTISSA_WIDTH(23), .ROUND_MODE(1), .TAG_WIDTH(4)) dut_rne (
        .clock(clock), .reset(reset), .valid_in(valid_in), .ready_in(ready_in),
        .a_in(a_in), .b_in(b_in), .tag_in(tag_in), .valid_out(valid_out),
        .ready_out(ready_out), .fpm_out(fpm_out), .tag_out(tag_out),
        .overflow_out(overflow_out), .underflow_out(underflow_out)
    );

    fpm_pipelined #(.EXP_WIDTH(8), .MANTISSA_WIDTH(23), .ROUND_MODE(0), .TAG_WIDTH(4)) dut_trn (
        .clock(clock), .reset(reset), .valid_in(valid_in), .ready_in(ready_in_t),
        .a_in(a_in), .b_in(b_in), .tag_in(tag_in), .valid_out(valid_out_t),
        .ready_out(ready_out), .fpm_out(fpm_out_t), .tag_out(tag_out_t),
        .overflow_out(overflow_out_t), .underflow_out(underflow_out_t)
    );

    typedef struct {
        logic [31:0] bits;
        logic        ovf;
        logic        unf;
    } res_t;

    typedef struct {
        res_t       rne;
        res_t       trn;
        logic [3:0] tag;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_popped = 0;
    logic started  = 1'b0;
    bit   sink_random = 1'b0;
    logic sink_level  = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: exact integer product of the significands, normalised by
    // magnitude and rounded with quotient/remainder arithmetic.
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input bit rne);
        res_t r;
        int ea, eb, e, k;
        longint unsigned ma, mb, p, q, rem, half;
        logic s;
        bit a_nan, b_nan, a_inf, b_inf;
        r.bits = 32'h0; r.ovf = 1'b0; r.unf = 1'b0;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        a_nan = (ea == 255) && (a[22:0] != 0);
        b_nan = (eb == 255) && (b[22:0] != 0);
        a_inf = (ea == 255) && (a[22:0] == 0);
        b_inf = (eb == 255) && (b[22:0] == 0);
        if (a_nan || b_nan || (a_inf && eb == 0) || (b_inf && ea == 0)) begin
            r.bits = 32'h7FC00000;
            return r;
        end
        if (a_inf || b_inf) begin
            r.bits = {s, 8'hFF, 23'h0};
            return r;
        end
        if (ea == 0 || eb == 0) begin
            r.bits = {s, 31'h0};
            return r;
        end
        ma = 64'(a[22:0]) + (64'd1 << 23);
        mb = 64'(b[22:0]) + (64'd1 << 23);
        p  = ma * mb;
        k  = (p >= (64'd1 << 47)) ? 24 : 23;
        e  = ea + eb - 127 + (k - 23);
        q  = p >> k;
        rem  = p - (q << k);
        half = 64'd1 << (k - 1);
        if (rne && (rem > half || (rem == half && q[0]))) q = q + 1;
        if (q == (64'd1 << 24)) begin
            q = 64'd1 << 23;
            e = e + 1;
        end
        if (e >= 255) begin
            r.bits = {s, 8'hFF, 23'h0};
            r.ovf  = 1'b1;
        end else if (e <= 0) begin
            r.bits = {s, 31'h0};
            r.unf  = 1'b1;
        end else begin
            r.bits = {s, 8'(e), 23'(q)};
        end
        return r;
    endfunction

    function automatic exp_t mk_exp(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
        exp_t x;
        x.rne = model(a, b, 1'b1);
        x.trn = model(a, b, 1'b0);
        x.tag = t;
        return x;
    endfunction

    function automatic exp_t dexp(input logic [31:0] rbits, input logic rovf, input logic runf,
                                  input logic [31:0] tbits, input logic tovf, input logic tunf,
                                  input logic [3:0] t);
        exp_t x;
        x.rne.bits = rbits; x.rne.ovf = rovf; x.rne.unf = runf;
        x.trn.bits = tbits; x.trn.ovf = tovf; x.trn.unf = tunf;
        x.tag = t;
        return x;
    endfunction

    function automatic logic [31:0] rand_op();
        logic [7:0]  e;
        logic [22:0] f;
        int sel;
        sel = $urandom_range(0, 15);
        f = 23'($urandom);
        if (sel == 0) e = 8'h00;
        else if (sel == 1) begin
            e = 8'hFF;
            if ($urandom_range(0, 1) == 0) f = '0;
        end else if (sel < 6) e = 8'($urandom_range(1, 254));
        else e = 8'($urandom_range(100, 154));
        if (sel == 2 || sel == 7) f = f & 23'h7FF000;
        return {1'($urandom), e, f};
    endfunction

    // ---------------- monitor ----------------
    exp_t        mon_e;
    logic        prev_stall = 1'b0;
    logic [31:0] hold_f;
    logic [3:0]  hold_t;
    logic [1:0]  hold_fl;

    always @(negedge clock) begin
        if (started) begin
            if (prev_stall) begin
                check("hold_valid", 32'(valid_out), 32'd1);
                check("hold_data", fpm_out, hold_f);
                check("hold_tag", 32'(tag_out), 32'(hold_t));
                check("hold_flags", 32'({overflow_out, underflow_out}), 32'(hold_fl));
            end
            if (valid_out && ready_out) begin
                if (sbq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_result: got tag %h data %h, expected no result", tag_out, fpm_out);
                end else begin
                    mon_e = sbq.pop_front();
                    n_popped++;
                    check("rne_data", fpm_out, mon_e.rne.bits);
                    check("rne_flags", 32'({overflow_out, underflow_out}), 32'({mon_e.rne.ovf, mon_e.rne.unf}));
                    check("rne_tag", 32'(tag_out), 32'(mon_e.tag));
                    check("trn_valid", 32'(valid_out_t), 32'd1);
                    check("trn_data", fpm_out_t, mon_e.trn.bits);
                    check("trn_flags", 32'({overflow_out_t, underflow_out_t}), 32'({mon_e.trn.ovf, mon_e.trn.unf}));
                    check("trn_tag", 32'(tag_out_t), 32'(mon_e.tag));
                end
            end
            prev_stall = valid_out && !ready_out && !reset;
            hold_f  = fpm_out;
            hold_t  = tag_out;
            hold_fl = {overflow_out, underflow_out};
        end
    end

    // ---------------- driver ----------------
    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] t, input exp_t ex, output logic acc);
        valid_in  = v;
        a_in      = a;
        b_in      = b;
        tag_in    = t;
        ready_out = sink_random ? ($urandom_range(0, 3) != 0) : sink_level;
        @(negedge clock);
        acc = v && ready_in;
        if (acc) sbq.push_back(ex);
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        logic acc;
        exp_t ex;
        ex = dexp('0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        drive(1'b0, '0, '0, '0, ex, acc);
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t, input exp_t ex);
        logic acc;
        int n;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 64) begin
            drive(1'b1, a, b, t, ex, acc);
            n++;
        end
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got no accept in %0d cycles, expected accept", n);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        sink_random = 1'b0;
        sink_level  = 1'b1;
        while (sbq.size() != 0 && n < 64) begin
            idle();
            n++;
        end
        idle();
        check("drain_empty", 32'(sbq.size()), 32'd0);
    endtask

    logic [31:0] ra, rb;
    logic        acc5;
    int          n0;

    initial begin
        reset = 1'b1; valid_in = 1'b0; a_in = '0; b_in = '0; tag_in = '0; ready_out = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        check("reset_valid_out", 32'(valid_out), 32'd0);
        check("reset_fpm_out", fpm_out, 32'd0);
        check("reset_tag_out", 32'(tag_out), 32'd0);
        check("reset_flags", 32'({overflow_out, underflow_out}), 32'd0);
        check("reset_ready_in", 32'(ready_in), 32'd1);
        check("reset_trn_valid", 32'(valid_out_t), 32'd0);
        started = 1'b1;

        // T1: basic product and latency
        send(32'h40400000, 32'h40200000, 4'd1,
             dexp(32'h40F00000, 0, 0, 32'h40F00000, 0, 0, 4'd1));
        check("t1_valid_edge1", 32'(valid_out), 32'd0);
        idle();
        check("t1_valid_edge2", 32'(valid_out), 32'd0);
        idle();
        check("t1_valid_edge3", 32'(valid_out), 32'd1);
        drain();

        // T2-T4: overflow, underflow, rounding, specials
        send(32'h7F000000, 32'h40000000, 4'd2, dexp(32'h7F800000, 1, 0, 32'h7F800000, 1, 0, 4'd2));
        send(32'h00800000, 32'h3F000000, 4'd3, dexp(32'h00000000, 0, 1, 32'h00000000, 0, 1, 4'd3));
        send(32'h3FC00001, 32'h3FC00001, 4'd4, dexp(32'h40100002, 0, 0, 32'h40100001, 0, 0, 4'd4));
        send(32'h7F800000, 32'h00000000, 4'd5, dexp(32'h7FC00000, 0, 0, 32'h7FC00000, 0, 0, 4'd5));
        send(32'hFF800000, 32'h40000000, 4'd6, dexp(32'hFF800000, 0, 0, 32'hFF800000, 0, 0, 4'd6));
        send(32'h80000000, 32'h3F800000, 4'd7, dexp(32'h80000000, 0, 0, 32'h80000000, 0, 0, 4'd7));
        drain();

        // T5: backpressure for 6 cycles with a stream of 5 ops
        n0 = n_popped;
        for (int i = 0; i < 4; i++) begin
            ra = rand_op();
            rb = rand_op();
            send(ra, rb, 4'(i), mk_exp(ra, rb, 4'(i)));
        end
        ra = rand_op();
        rb = rand_op();
        sink_level = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, ra, rb, 4'd4, mk_exp(ra, rb, 4'd4), acc5);
            check("t5_stall_ready_in", 32'(acc5), 32'd0);
        end
        sink_level = 1'b1;
        send(ra, rb, 4'd4, mk_exp(ra, rb, 4'd4));
        drain();
        check("t5_result_count", 32'(n_popped - n0), 32'd5);

        // T6: reset with three ops in flight
        for (int i = 0; i < 3; i++) begin
            ra = rand_op();
            rb = rand_op();
            send(ra, rb, 4'(8 + i), mk_exp(ra, rb, 4'(8 + i)));
        end
        valid_in  = 1'b0;
        ready_out = 1'b0;
        reset     = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        sbq.delete();
        check("t6_valid_after_reset", 32'(valid_out), 32'd0);
        check("t6_fpm_after_reset", fpm_out, 32'd0);
        repeat (4) idle();
        send(32'h40400000, 32'h40200000, 4'd12,
             dexp(32'h40F00000, 0, 0, 32'h40F00000, 0, 0, 4'd12));
        drain();

        // Randomised stream with gaps and random backpressure
        sink_random = 1'b1;
        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 2)) idle();
            ra = rand_op();
            rb = rand_op();
            send(ra, rb, 4'(i), mk_exp(ra, rb, 4'(i)));
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
